// File: rtl/debug_controller.sv
// debug_controller: UART-driven run/step/pause control of the MIPS pipeline with a PC/GPR/cycle-count byte dump
module debug_controller #(
  parameter int B      = 32,
  parameter int W      = 5,
  parameter int NWORDS = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  input  logic         tx_busy,
  input  logic         tx_done,
  output logic         tx_start,
  output logic [7:0]   tx_data,
  input  logic         halt_in,
  input  logic [B-1:0] pc_value,
  input  logic [B-1:0] reg_value,
  output logic [W-1:0] reg_sel,
  output logic         pipe_en,
  output logic         halted,
  output logic         busy
);
  localparam int WI = $clog2(NWORDS);
  localparam int NB = B / 8;
  localparam int BI = (NB > 1) ? $clog2(NB) : 1;
  typedef enum logic [2:0] {IDLE, RUN, STEP, LOAD, SEND, WAIT} state_t;
  state_t        state;
  logic [WI-1:0] word_idx;
  logic [BI-1:0] byte_idx;
  logic [B-1:0]  shift, cycle_count, load_word;
  logic          last_word;
  assign last_word = word_idx == WI'(NWORDS - 1);
  // word 0 is the PC, the final word is the cycle counter, everything between is a GPR
  assign reg_sel   = (word_idx == '0) ? '0 : W'(word_idx - 1'b1);
  assign load_word = (word_idx == '0) ? pc_value : last_word ? cycle_count : reg_value;
  assign pipe_en   = (state == RUN) || (state == STEP);
  assign busy      = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      shift       <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (rx_done) begin
          if (rx_data == 8'h63 && !halted) state <= RUN;
          else if (rx_data == 8'h73 && !halted) state <= STEP;
          else if (rx_data == 8'h64) state <= LOAD;
        end
        RUN: begin
          cycle_count <= cycle_count + 1'b1;
          if (halt_in) begin
            halted <= 1'b1;
            state  <= LOAD;
          end else if (rx_done && rx_data == 8'h70) state <= LOAD;
        end
        STEP: begin
          cycle_count <= cycle_count + 1'b1;
          if (halt_in) halted <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          shift    <= load_word;
          byte_idx <= BI'(NB - 1);
          state    <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= shift[B-1 -: 8];
          state    <= WAIT;
        end
        WAIT: if (tx_done) begin
          shift <= shift << 8;
          if (byte_idx != '0) begin
            byte_idx <= byte_idx - 1'b1;
            state    <= SEND;
          end else if (last_word) begin
            word_idx <= '0;
            state    <= IDLE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_controller.sv
// tb_debug_controller: scoreboard bench for debug_controller with a UART TX model and directed command sequences
module tb_debug_controller;
  logic        clk = 1'b0, reset = 1'b1, rx_done = 1'b0, tx_busy, tx_busy_m = 1'b0, tx_done = 1'b0;
  logic        halt_in = 1'b0, bp = 1'b0, tx_start, pipe_en, halted, busy;
  logic [7:0]  rx_data = 8'h00, tx_data;
  logic [31:0] pc_value = 32'h10, reg_value;
  logic [4:0]  reg_sel;
  logic [31:0] rf [32];
  logic [7:0]  exp_q [$];
  int n_checks = 0, n_pass = 0, nbytes = 0, pe_cnt = 0;

  always #5 clk = ~clk;
  assign tx_busy   = tx_busy_m | bp;
  assign reg_value = rf[reg_sel];

  debug_controller dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data), .halt_in(halt_in),
    .pc_value(pc_value), .reg_value(reg_value), .reg_sel(reg_sel), .pipe_en(pipe_en),
    .halted(halted), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_dump(input logic [31:0] cyc);
    logic [31:0] w;
    for (int i = 0; i < 34; i++) begin
      w = (i == 0) ? pc_value : (i == 33) ? cyc : rf[i-1];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, 32'(busy), 0);
    chk({name, "_qempty"}, exp_q.size(), 0);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (nbytes < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_bytes", 32'(nbytes >= n), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_pipe_en"}, 32'(pipe_en), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_halted"}, 32'(halted), 0);
    chk({name, "_tx_start"}, 32'(tx_start), 0);
    chk({name, "_tx_data"}, 32'(tx_data), 0);
    chk({name, "_reg_sel"}, 32'(reg_sel), 0);
  endtask

  // monitor: every tx_start byte is matched against the scoreboard
  initial forever begin
    @(negedge clk);
    if (pipe_en) pe_cnt++;
    if (tx_start) begin
      nbytes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_tx_start: got %h expected no byte", tx_data);
      end else chk($sformatf("byte%0d", nbytes - 1), 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // UART transmitter model: busy for a few cycles, then a one-cycle done pulse
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      tx_busy_m = 1'b1;
      repeat (3) @(negedge clk);
      tx_busy_m = 1'b0;
      tx_done   = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  initial begin
    int n0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[5] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("init");
    // plain dump from reset
    nbytes = 0; pe_cnt = 0;
    push_dump(32'd0);
    send_byte(8'h64);
    wait_idle("dump0");
    chk("dump0_bytes", nbytes, 136);
    chk("dump0_pipe_en", pe_cnt, 0);
    // reset in the middle of a dump, then restart
    nbytes = 0;
    push_dump(32'd0);
    send_byte(8'h64);
    wait_bytes(51);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    n0 = nbytes;
    repeat (20) @(negedge clk);
    chk("midrst_no_tx", nbytes, n0);
    nbytes = 0;
    push_dump(32'd0);
    send_byte(8'h64);
    wait_idle("restart");
    chk("restart_bytes", nbytes, 136);
    // two single steps
    pc_value = 32'h44;
    rf[31] = 32'hA5A50F0F;
    nbytes = 0; pe_cnt = 0;
    push_dump(32'd1);
    send_byte(8'h73);
    wait_idle("step1");
    chk("step1_pipe_en", pe_cnt, 1);
    pe_cnt = 0;
    push_dump(32'd2);
    send_byte(8'h73);
    wait_idle("step2");
    chk("step2_pipe_en", pe_cnt, 1);
    chk("step2_halted", 32'(halted), 0);
    // run until halt on the 10th run cycle
    do_reset();
    pe_cnt = 0;
    push_dump(32'd10);
    send_byte(8'h63);
    repeat (9) @(posedge clk);
    #1 halt_in = 1'b1;
    @(posedge clk); #1 halt_in = 1'b0;
    wait_idle("halt");
    chk("halt_pipe_en", pe_cnt, 10);
    chk("halt_halted", 32'(halted), 1);
    pe_cnt = 0;
    send_byte(8'h63);
    repeat (5) @(negedge clk);
    chk("halted_c_busy", 32'(busy), 0);
    send_byte(8'h73);
    repeat (5) @(negedge clk);
    chk("halted_s_busy", 32'(busy), 0);
    chk("halted_pipe_en", pe_cnt, 0);
    push_dump(32'd10);
    send_byte(8'h64);
    wait_idle("halted_d");
    chk("halted_d_halted", 32'(halted), 1);
    // run then pause after 5 cycles; a stray byte mid-dump is ignored
    do_reset();
    chk("pause_rst_halted", 32'(halted), 0);
    nbytes = 0; pe_cnt = 0;
    push_dump(32'd5);
    send_byte(8'h63);
    repeat (3) @(posedge clk);
    send_byte(8'h70);
    wait_bytes(20);
    send_byte(8'h78);
    wait_idle("pause");
    chk("pause_pipe_en", pe_cnt, 5);
    chk("pause_halted", 32'(halted), 0);
    chk("pause_bytes", nbytes, 136);
    // transmitter backpressure at byte 7
    nbytes = 0;
    push_dump(32'd5);
    send_byte(8'h64);
    wait_bytes(7);
    bp = 1'b1;
    n0 = nbytes;
    repeat (20) @(negedge clk);
    chk("bp_hold", nbytes, n0);
    bp = 1'b0;
    wait_idle("bp");
    chk("bp_bytes", nbytes, 136);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/debug_controller.md
Name: debug_controller

Overview:
- Sequences the MIPS pipeline for on-board debug.
- Gates the pipeline clock-enable in continuous-run or single-step mode, driven by command bytes from a UART receiver.
- After each run, step or dump request, reads out PC, all 32 GPRs (via the register-file debug taps) and an internal cycle counter, one byte at a time, to a UART transmitter.
- Sits between the UART RX/TX pair and the top-level pipeline.

Parameters:
- B, 32, data word width (PC, registers, cycle counter)
- W, 5, register address width
- NWORDS, 34, words per dump: PC + 32 GPRs + cycle count

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received command byte
- rx_done  input  1  one-cycle pulse: rx_data valid
- tx_busy  input  1  transmitter shifting a byte
- tx_done  input  1  one-cycle pulse: byte fully sent
- tx_start  output  1  one-cycle pulse: send tx_data
- tx_data  output  8  byte to send
- halt_in  input  1  pipeline retired HALT instruction
- pc_value  input  B  current PC
- reg_value  input  B  GPR selected by reg_sel (external combinational mux)
- reg_sel  output  W  GPR index to read
- pipe_en  output  1  pipeline clock enable
- halted  output  1  sticky: HALT reached
- busy  output  1  controller not in IDLE

Behaviour:
- Reset (synchronous, active-high), applied on any cycle including mid-dump or mid-run:
  - state=IDLE.
  - pipe_en=0, tx_start=0, tx_data=0, reg_sel=0, busy=0, halted=0.
  - cycle_count=0, word_idx=0, byte_idx=0.
  - Any pending byte is abandoned.
- Commands are decoded only in IDLE on rx_done; any other byte is ignored.
  - 0x63 'c' → RUN.
  - 0x73 's' → STEP.
  - 0x64 'd' → LOAD.
  - In IDLE, when halted=1, 'c' and 's' are ignored; 'd' is still accepted.
- RUN:
  - pipe_en=1 every cycle; cycle_count+1 every cycle.
  - If halt_in=1 sampled, that cycle still counts: set halted, go to LOAD.
  - If rx_done with 0x70 'p', go to LOAD with halted unchanged. If halt_in and 'p' occur in the same cycle, halt_in wins and halted is set.
  - All other bytes in RUN are ignored.
- STEP:
  - pipe_en=1 for exactly one cycle; cycle_count+1.
  - If halt_in=1 in that cycle, set halted.
  - Next state is LOAD.
- pipe_en is a Moore output: 1 exactly in RUN/STEP, 0 in every other state.
- LOAD: capture word word_idx into a B-bit shift register.
  - word 0 = pc_value.
  - words 1..32 = reg_value with reg_sel=word_idx-1 (reg_sel driven combinationally from registered word_idx).
  - word 33 = cycle_count.
  - Then byte_idx=3, go to SEND.
- SEND: when tx_busy=0, assert tx_start for one cycle with tx_data = shift[31:24], then go to WAIT. While tx_busy=1, stay in SEND with tx_start=0.
- WAIT: on tx_done, shift left 8, then:
  - if byte_idx≠0, decrement byte_idx and go to SEND;
  - else, if word_idx=NWORDS-1, go to IDLE with word_idx=0;
  - else word_idx+1 and go to LOAD.
- Dump length and order:
  - Always 136 bytes, MSB first per word.
  - Order: PC, r0..r31, cycle_count.
  - The values of rx_done/rx_data during LOAD/SEND/WAIT are ignored.
- cycle_count: 32-bit, wraps from 0xFFFFFFFF to 0; cleared only by reset.
- busy = (state≠IDLE).

Test Plan:
- Reset mid-dump (after byte 50) → next cycle: all outputs at reset values, no further tx_start; a subsequent 'd' restarts from PC byte 0.
- From reset, pc_value=0x00000010, reg5=0xDEADBEEF, others 0, send 'd' → 136 tx_start pulses, pipe_en stays 0 throughout:
  - bytes 0..3 = 00 00 00 10;
  - bytes 24..27 = DE AD BE EF;
  - bytes 132..135 = 00 00 00 00.
- 's' twice (each dump completed) → pipe_en high exactly one cycle per command; last 4 bytes of second dump = 00 00 00 02.
- 'c', halt_in pulsed on the 10th RUN cycle → pipe_en high for exactly 10 cycles, halted=1, cycle bytes = 00 00 00 0A; following 'c' and 's' ignored (busy stays 0), 'd' accepted.
- 'c' then 'p' after 5 cycles → dump starts, halted=0, cycle bytes = 00 00 00 05; a byte 'x' (0x78) sent during the dump has no effect.
- Backpressure: hold tx_busy=1 for 20 cycles at byte 7 → tx_start held 0, byte order and values unchanged, dump still totals 136 bytes.
